rank_dispatch: RTL and testbench
================================

# rank_dispatch

Parametrised rank front-end between the system command port and `NUM_RANKS` slice controllers (`Ctrl`). It decodes the rank field of each command, buffers it in a per-rank command FIFO with a valid/ready handshake, and returns read data from all ranks through buffered, round-robin-arbitrated return logic. It replaces the combinational rank-select package with one that accepts back-pressure, lets ranks run concurrently and never silently drops simultaneous read returns.

## Interface

**Parameters**
- `NUM_RANKS`, default 4: number of ranks; power of two, at least 2.
- `RANK_BITS`, default 2: log2(`NUM_RANKS`).
- `CMD_W`, default 32: per-rank command width.
- `DATA_W`, default 128: write/read data width (`DQ_BITS`*8).
- `FIFO_DEPTH`, default 4: entries per rank command FIFO; power of two, at least 2.

**Ports**
- `clk` input 1: single clock; all logic is rising-edge.
- `i_power_on_rst_n` input 1: asynchronous, active-low reset.
- `i_command` input `RANK_BITS+CMD_W`: bits [`CMD_W+RANK_BITS-1`:`CMD_W`] are the rank; bits [`CMD_W-1`:0] are the command.
- `i_write_data` input `DATA_W`: write data accompanying the command.
- `i_valid` input 1: command offered.
- `o_ready` output 1: the addressed rank's FIFO can accept the command.
- `o_rank_command` output `NUM_RANKS*CMD_W`: FIFO head per rank; rank r occupies slice r.
- `o_rank_write_data` output `NUM_RANKS*DATA_W`: FIFO head write data per rank.
- `o_rank_valid` output `NUM_RANKS`: FIFO r is non-empty.
- `i_rank_ready` input `NUM_RANKS`: rank r consumes its FIFO head.
- `i_rank_read_data` input `NUM_RANKS*DATA_W`: read data per rank.
- `i_rank_read_valid` input `NUM_RANKS`: single-cycle read-data pulse per rank; no back-pressure.
- `i_rank_ba_cmd_pm` input `NUM_RANKS*4`: bank command/power-mode status per rank.
- `o_read_data` output `DATA_W`: arbitrated read data.
- `o_read_data_valid` output 1: `o_read_data` valid, one-cycle pulse per beat.
- `o_read_rank` output `RANK_BITS`: rank that sourced `o_read_data`.
- `o_ba_cmd_pm` output 4: status of the rank of the most recently accepted command.
- `o_overflow` output 1: sticky flag; a read beat was lost.

## Operation

**Command path**
- The rank is decoded as `sel = i_command[CMD_W+RANK_BITS-1:CMD_W]`.
- `o_ready = !full[sel]`. This is combinational and ignores any same-cycle pop, so there is no bypass-on-full.
- A push happens when `i_valid && o_ready`: {command, write data} is written into FIFO[`sel`]. Other FIFOs are untouched.
- A pop of FIFO r happens when `o_rank_valid[r] && i_rank_ready[r]`.
- Each FIFO holds a count of 0..`FIFO_DEPTH`, with read and write pointers that wrap modulo `FIFO_DEPTH`.
- A simultaneous push and pop on the same FIFO leaves the count unchanged. This is legal whenever the FIFO is not full.
- When `o_rank_valid[r]` is 0, `o_rank_command` and `o_rank_write_data` slice r are driven to 0.
- On every accepted push, a last-rank register is loaded with `sel`. `o_ba_cmd_pm` is the combinational mux of `i_rank_ba_cmd_pm` by that register.

**Read return**
- Each rank has a one-entry holding register {pend[r], data[r]}.
- A pulse on `i_rank_read_valid[r]` writes `data[r]` and sets `pend[r]`.
- A round-robin arbiter grants one pending rank per cycle. The search starts at `(last_grant+1) mod NUM_RANKS`, and `last_grant` updates on each grant.
- On a grant to rank g:
  - `o_read_data`, `o_read_rank` and `o_read_data_valid` are registered from `data[g]`, `g` and 1.
  - `pend[g]` clears unless a new pulse for g arrives in the same cycle. In that case the new beat is captured and `pend[g]` stays set, with no loss.
- A pulse arriving for rank r while `pend[r]` is set and r is not granted is dropped. `data[r]` keeps the old beat and `o_overflow` sets.
- `o_read_data` holds its last value while `o_read_data_valid` is 0.

**Reset**
- The reset is asynchronous and active-low.
- Reset clears all FIFO counts and pointers, all `pend` bits, `last_grant` (to `NUM_RANKS-1`, so rank 0 has first priority), the last-rank register (to 0), `o_read_data`, `o_read_rank`, `o_read_data_valid` and `o_overflow`.
- After reset: `o_rank_valid` = 0, `o_ready` = 1, `o_ba_cmd_pm` = `i_rank_ba_cmd_pm` slice 0.
- A reset asserted mid-operation discards all queued commands and pending beats.

## Timing

- **Command latency:** a push at edge t into an empty FIFO gives `o_rank_valid[r]` = 1 from t+1.
- **Command throughput:** one command per cycle system-wide; one push and one pop per FIFO per cycle.
- **`o_ready` after pop:** deasserts the cycle after the push that fills the FIFO, and reasserts the cycle after the pop from full.
- **Read latency:** a rank pulse in cycle t is captured at the end of t, granted in t+1, and appears on `o_read_data_valid` in t+2.
- **Read throughput:** one beat per cycle aggregate. A single rank pulsing every cycle is sustained with no overflow.
- **Worst-case drain:** simultaneous pulses from all ranks drain in `NUM_RANKS` cycles. A second pulse from a still-pending rank overflows.

## Test plan

- **Reset and first command:** hold reset, release, send rank 2 command 0x12345678 with `i_rank_ready` = 0 -> `o_ready` = 1; `o_rank_valid` = 4'b0100 from the next cycle; slice 2 = 0x12345678; `o_ba_cmd_pm` = rank 2 status.
- **Full FIFO:** 5 back-to-back rank 0 commands with `i_rank_ready[0]` = 0 and `FIFO_DEPTH` = 4 -> 4 are accepted and `o_ready` = 0 on the 5th. Set `i_rank_ready[0]` = 1 -> the 4 commands emerge in order, and the 5th is accepted the cycle after the first pop.
- **Concurrent traffic:** commands interleaved to ranks 0, 1, 0, 3 while rank 1 is stalled -> ranks 0 and 3 drain normally and rank 1 holds its head.
- **Simultaneous read returns:** all 4 ranks pulse in one cycle with data 0xA0..0xA3 -> beats are output on 4 consecutive cycles in rank order 0, 1, 2, 3 starting 2 cycles later; `o_overflow` = 0. A repeat burst in the same manner starts at rank 0, the round-robin successor of the last grant, rank 3.
- **Overflow:** rank 1 pulses twice while rank 0 is pending and granted first -> the second rank 1 beat is dropped, `o_overflow` = 1 and stays set until reset.
- **Reset mid-operation:** assert reset with 3 queued commands and 2 pending beats -> all outputs return to their reset values immediately, and no stale beat or command appears after release.

Source files
------------

// File: rtl/rank_dispatch_if.sv
// System-side and rank-side signals of the rank dispatcher, grouped for port connection.
// slave is the dispatcher's view; master is the view of whatever drives it.
interface rank_dispatch_if #(
   parameter int unsigned NUM_RANKS = 4,
   parameter int unsigned RANK_BITS = 2,
   parameter int unsigned CMD_W     = 32,
   parameter int unsigned DATA_W    = 128
);
   logic [RANK_BITS+CMD_W-1:0]  i_command;
   logic [DATA_W-1:0]           i_write_data;
   logic                        i_valid;
   logic                        o_ready;
   logic [NUM_RANKS*CMD_W-1:0]  o_rank_command;
   logic [NUM_RANKS*DATA_W-1:0] o_rank_write_data;
   logic [NUM_RANKS-1:0]        o_rank_valid;
   logic [NUM_RANKS-1:0]        i_rank_ready;
   logic [NUM_RANKS*DATA_W-1:0] i_rank_read_data;
   logic [NUM_RANKS-1:0]        i_rank_read_valid;
   logic [NUM_RANKS*4-1:0]      i_rank_ba_cmd_pm;
   logic [DATA_W-1:0]           o_read_data;
   logic                        o_read_data_valid;
   logic [RANK_BITS-1:0]        o_read_rank;
   logic [3:0]                  o_ba_cmd_pm;
   logic                        o_overflow;

   modport slave (
      input  i_command, i_write_data, i_valid, i_rank_ready,
      input  i_rank_read_data, i_rank_read_valid, i_rank_ba_cmd_pm,
      output o_ready, o_rank_command, o_rank_write_data, o_rank_valid,
      output o_read_data, o_read_data_valid, o_read_rank, o_ba_cmd_pm, o_overflow
   );

   modport master (
      output i_command, i_write_data, i_valid, i_rank_ready,
      output i_rank_read_data, i_rank_read_valid, i_rank_ba_cmd_pm,
      input  o_ready, o_rank_command, o_rank_write_data, o_rank_valid,
      input  o_read_data, o_read_data_valid, o_read_rank, o_ba_cmd_pm, o_overflow
   );
endinterface

// File: rtl/rank_dispatch.sv
// Rank front-end: per-rank command FIFOs with valid/ready back-pressure, and
// round-robin arbitration of buffered single-entry read returns from all ranks.
module rank_dispatch #(
   parameter int unsigned NUM_RANKS  = 4,
   parameter int unsigned RANK_BITS  = 2,
   parameter int unsigned CMD_W      = 32,
   parameter int unsigned DATA_W     = 128,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input logic            clk,
   input logic            i_power_on_rst_n,
   rank_dispatch_if.slave bus
);
   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   // Command path
   logic [RANK_BITS-1:0]        sel;
   logic                        ready;
   logic [NUM_RANKS-1:0]        full;
   logic [NUM_RANKS-1:0]        rank_valid;
   logic [NUM_RANKS-1:0]        push;
   logic [NUM_RANKS-1:0]        pop;
   logic [NUM_RANKS*CMD_W-1:0]  rank_cmd;
   logic [NUM_RANKS*DATA_W-1:0] rank_wdata;

   logic [CMD_W-1:0]  cmd_mem   [NUM_RANKS][FIFO_DEPTH];
   logic [DATA_W-1:0] wdata_mem [NUM_RANKS][FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q  [NUM_RANKS];
   logic [PTR_W-1:0]  rd_ptr_q  [NUM_RANKS];
   logic [CNT_W-1:0]  count_q   [NUM_RANKS];
   logic [RANK_BITS-1:0] last_rank_q;

   assign sel   = bus.i_command[CMD_W+RANK_BITS-1:CMD_W];
   // Full is judged on the registered count only: no bypass when a pop coincides.
   assign ready = !full[sel];

   always_comb begin
      full       = '0;
      rank_valid = '0;
      push       = '0;
      pop        = '0;
      rank_cmd   = '0;
      rank_wdata = '0;
      for (int r = 0; r < NUM_RANKS; r++) begin
         full[r]       = (count_q[r] == CNT_W'(FIFO_DEPTH));
         rank_valid[r] = (count_q[r] != '0);
         push[r]       = bus.i_valid && ready && (sel == RANK_BITS'(r));
         pop[r]        = rank_valid[r] && bus.i_rank_ready[r];
         if (rank_valid[r]) begin
            rank_cmd[r*CMD_W +: CMD_W]     = cmd_mem[r][rd_ptr_q[r]];
            rank_wdata[r*DATA_W +: DATA_W] = wdata_mem[r][rd_ptr_q[r]];
         end
      end
   end

   always_ff @(posedge clk or negedge i_power_on_rst_n) begin
      if (!i_power_on_rst_n) begin
         for (int r = 0; r < NUM_RANKS; r++) begin
            wr_ptr_q[r] <= '0;
            rd_ptr_q[r] <= '0;
            count_q[r]  <= '0;
         end
         last_rank_q <= '0;
      end else begin
         for (int r = 0; r < NUM_RANKS; r++) begin
            if (push[r]) wr_ptr_q[r] <= wr_ptr_q[r] + PTR_W'(1);
            if (pop[r])  rd_ptr_q[r] <= rd_ptr_q[r] + PTR_W'(1);
            if (push[r] && !pop[r]) begin
               count_q[r] <= count_q[r] + CNT_W'(1);
            end else if (!push[r] && pop[r]) begin
               count_q[r] <= count_q[r] - CNT_W'(1);
            end
         end
         if (bus.i_valid && ready) last_rank_q <= sel;
      end
   end

   // Storage carries no reset; heads are masked by rank_valid.
   always_ff @(posedge clk) begin
      for (int r = 0; r < NUM_RANKS; r++) begin
         if (push[r]) begin
            cmd_mem[r][wr_ptr_q[r]]   <= bus.i_command[CMD_W-1:0];
            wdata_mem[r][wr_ptr_q[r]] <= bus.i_write_data;
         end
      end
   end

   assign bus.o_ready           = ready;
   assign bus.o_rank_valid      = rank_valid;
   assign bus.o_rank_command    = rank_cmd;
   assign bus.o_rank_write_data = rank_wdata;
   assign bus.o_ba_cmd_pm       = bus.i_rank_ba_cmd_pm[{last_rank_q, 2'b00} +: 4];

   // Read return
   logic [NUM_RANKS-1:0] pend_q;
   logic [DATA_W-1:0]    rdata_q [NUM_RANKS];
   logic [RANK_BITS-1:0] last_grant_q;
   logic [RANK_BITS-1:0] cand;
   logic [RANK_BITS-1:0] gnt_idx;
   logic                 gnt_any;
   logic [DATA_W-1:0]    read_data_q;
   logic [RANK_BITS-1:0] read_rank_q;
   logic                 read_valid_q;
   logic                 overflow_q;

   // Search wraps naturally because NUM_RANKS is a power of two; i == NUM_RANKS
   // lands back on last_grant_q, giving it lowest priority.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = last_grant_q;
      cand    = last_grant_q;
      for (int i = 1; i <= NUM_RANKS; i++) begin
         cand = last_grant_q + RANK_BITS'(i);
         if (!gnt_any && pend_q[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   always_ff @(posedge clk or negedge i_power_on_rst_n) begin
      if (!i_power_on_rst_n) begin
         pend_q       <= '0;
         last_grant_q <= RANK_BITS'(NUM_RANKS - 1);
         read_data_q  <= '0;
         read_rank_q  <= '0;
         read_valid_q <= 1'b0;
         overflow_q   <= 1'b0;
         for (int r = 0; r < NUM_RANKS; r++) rdata_q[r] <= '0;
      end else begin
         for (int r = 0; r < NUM_RANKS; r++) begin
            if (bus.i_rank_read_valid[r]) begin
               // A granted slot frees this cycle, so a new beat can land in it.
               if (!pend_q[r] || (gnt_any && gnt_idx == RANK_BITS'(r))) begin
                  rdata_q[r] <= bus.i_rank_read_data[r*DATA_W +: DATA_W];
                  pend_q[r]  <= 1'b1;
               end else begin
                  overflow_q <= 1'b1;
               end
            end else if (gnt_any && gnt_idx == RANK_BITS'(r)) begin
               pend_q[r] <= 1'b0;
            end
         end
         read_valid_q <= gnt_any;
         if (gnt_any) begin
            read_data_q  <= rdata_q[gnt_idx];
            read_rank_q  <= gnt_idx;
            last_grant_q <= gnt_idx;
         end
      end
   end

   assign bus.o_read_data       = read_data_q;
   assign bus.o_read_rank       = read_rank_q;
   assign bus.o_read_data_valid = read_valid_q;
   assign bus.o_overflow        = overflow_q;
endmodule

// File: tb/tb_rank_dispatch.sv
// Directed bench for rank_dispatch: stimulus queues expected FIFO pops and read
// beats; a negedge monitor pops and compares them as the DUT presents outputs.
module tb_rank_dispatch;
   localparam int NR = 4;
   localparam int RB = 2;
   localparam int CW = 32;
   localparam int DW = 128;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   rank_dispatch_if #(.NUM_RANKS(NR), .RANK_BITS(RB), .CMD_W(CW), .DATA_W(DW)) bus ();

   rank_dispatch #(
      .NUM_RANKS(NR), .RANK_BITS(RB), .CMD_W(CW), .DATA_W(DW), .FIFO_DEPTH(4)
   ) dut (
      .clk             (clk),
      .i_power_on_rst_n(rst_n),
      .bus             (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [RB-1:0] rank;
      logic [CW-1:0] cmd;
      logic [DW-1:0] data;
   } cmd_t;

   typedef struct {
      logic [RB-1:0] rank;
      logic [DW-1:0] data;
   } rd_t;

   cmd_t exp_cmd[$];
   rd_t  exp_rd[$];

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Offers one command for one cycle; called at posedge+1, returns at posedge+1.
   task automatic drive_cmd(input logic [RB-1:0] r, input logic [CW-1:0] c, output bit acc);
      cmd_t e;
      bus.i_valid      = 1'b1;
      bus.i_command    = {r, c};
      bus.i_write_data = {4{c}};
      @(negedge clk);
      acc = bus.o_ready;
      if (acc) begin
         e.rank = r;
         e.cmd  = c;
         e.data = {4{c}};
         exp_cmd.push_back(e);
      end
      @(posedge clk);
      #1;
      bus.i_valid = 1'b0;
   endtask

   task automatic expect_rd(input logic [RB-1:0] r, input logic [DW-1:0] d);
      rd_t e;
      e.rank = r;
      e.data = d;
      exp_rd.push_back(e);
   endtask

   // Monitor
   int   found;
   rd_t  got_rd;
   always @(negedge clk) begin
      for (int r = 0; r < NR; r++) begin
         if (rst_n && bus.o_rank_valid[r] && bus.i_rank_ready[r]) begin
            found = -1;
            for (int k = 0; k < exp_cmd.size(); k++) begin
               if (found < 0 && exp_cmd[k].rank == RB'(r)) found = k;
            end
            if (found < 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pop rank=%0d actual=%0h required=none", r,
                        bus.o_rank_command[r*CW +: CW]);
            end else begin
               check("pop_cmd", DW'(bus.o_rank_command[r*CW +: CW]), DW'(exp_cmd[found].cmd));
               check("pop_wdata", bus.o_rank_write_data[r*DW +: DW], exp_cmd[found].data);
               exp_cmd.delete(found);
            end
         end
      end
      if (bus.o_read_data_valid) begin
         if (exp_rd.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat actual=%0h required=none", bus.o_read_data);
         end else begin
            got_rd = exp_rd.pop_front();
            check("beat_data", bus.o_read_data, got_rd.data);
            check("beat_rank", DW'(bus.o_read_rank), DW'(got_rd.rank));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   bit acc;

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      bus.i_command         = '0;
      bus.i_write_data      = '0;
      bus.i_valid           = 1'b0;
      bus.i_rank_ready      = '0;
      bus.i_rank_read_data  = '0;
      bus.i_rank_read_valid = '0;
      bus.i_rank_ba_cmd_pm  = {4'hD, 4'hC, 4'hB, 4'hA};

      // Reset state
      @(negedge clk);
      check("rst_rank_valid", DW'(bus.o_rank_valid), 0);
      check("rst_ready", DW'(bus.o_ready), 1);
      check("rst_ba_cmd_pm", DW'(bus.o_ba_cmd_pm), 'hA);
      check("rst_read_valid", DW'(bus.o_read_data_valid), 0);
      check("rst_overflow", DW'(bus.o_overflow), 0);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // First command to rank 2
      drive_cmd(2'd2, 32'h12345678, acc);
      check("first_acc", DW'(acc), 1);
      @(negedge clk);
      check("first_rank_valid", DW'(bus.o_rank_valid), 'b0100);
      check("first_slice2", DW'(bus.o_rank_command[2*CW +: CW]), 'h12345678);
      check("first_ba_cmd_pm", DW'(bus.o_ba_cmd_pm), 'hC);
      @(posedge clk);
      #1 bus.i_rank_ready = 4'b0100;
      cycles(1);
      bus.i_rank_ready = 4'b0000;

      // Full FIFO on rank 0
      for (int i = 0; i < 4; i++) begin
         drive_cmd(2'd0, 32'h100 + i, acc);
         check("full_acc", DW'(acc), 1);
      end
      bus.i_rank_ready = 4'b0001;
      drive_cmd(2'd0, 32'h104, acc);
      check("full_5th_blocked", DW'(acc), 0);
      drive_cmd(2'd0, 32'h104, acc);
      check("full_5th_after_pop", DW'(acc), 1);
      cycles(6);
      @(negedge clk);
      check("full_drained", DW'(bus.o_rank_valid), 0);
      @(posedge clk);
      #1;

      // Concurrent traffic with rank 1 stalled
      bus.i_rank_ready = 4'b1001;
      drive_cmd(2'd0, 32'h200, acc);
      drive_cmd(2'd1, 32'h201, acc);
      drive_cmd(2'd0, 32'h202, acc);
      drive_cmd(2'd3, 32'h203, acc);
      check("conc_acc", DW'(acc), 1);
      cycles(3);
      @(negedge clk);
      check("conc_rank_valid", DW'(bus.o_rank_valid), 'b0010);
      check("conc_slice1", DW'(bus.o_rank_command[1*CW +: CW]), 'h201);
      @(posedge clk);
      #1 bus.i_rank_ready = 4'b1111;
      cycles(2);
      bus.i_rank_ready = 4'b0000;

      // Simultaneous read returns, twice
      for (int b = 0; b < 2; b++) begin
         for (int r = 0; r < NR; r++) begin
            bus.i_rank_read_data[r*DW +: DW] = DW'((b == 0 ? 'hA0 : 'hB0) + r);
            expect_rd(RB'(r), DW'((b == 0 ? 'hA0 : 'hB0) + r));
         end
         bus.i_rank_read_valid = 4'b1111;
         cycles(1);
         bus.i_rank_read_valid = 4'b0000;
         @(negedge clk);
         check("rd_lat_t1", DW'(bus.o_read_data_valid), 0);
         @(negedge clk);
         check("rd_lat_t2", DW'(bus.o_read_data_valid), 1);
         cycles(6);
      end
      check("rd_no_overflow", DW'(bus.o_overflow), 0);

      // Overflow: rank 1 pulses again while still pending behind rank 0
      bus.i_rank_read_data[0*DW +: DW] = DW'('hC0);
      bus.i_rank_read_data[1*DW +: DW] = DW'('hC1);
      bus.i_rank_read_valid = 4'b0011;
      expect_rd(2'd0, DW'('hC0));
      expect_rd(2'd1, DW'('hC1));
      cycles(1);
      bus.i_rank_read_data[1*DW +: DW] = DW'('hC2);
      bus.i_rank_read_valid = 4'b0010;
      cycles(1);
      bus.i_rank_read_valid = 4'b0000;
      @(negedge clk);
      check("ovf_set", DW'(bus.o_overflow), 1);
      cycles(6);
      check("ovf_sticky", DW'(bus.o_overflow), 1);

      // Reset mid-operation
      drive_cmd(2'd0, 32'h300, acc);
      drive_cmd(2'd1, 32'h301, acc);
      drive_cmd(2'd2, 32'h302, acc);
      bus.i_rank_read_data[2*DW +: DW] = DW'('hD2);
      bus.i_rank_read_data[3*DW +: DW] = DW'('hD3);
      bus.i_rank_read_valid = 4'b1100;
      @(negedge clk);
      check("pre_rst_ba_cmd_pm", DW'(bus.o_ba_cmd_pm), 'hC);
      check("pre_rst_rank_valid", DW'(bus.o_rank_valid), 'b0111);
      @(posedge clk);
      #1;
      bus.i_rank_read_valid = 4'b0000;
      rst_n = 1'b0;
      exp_cmd.delete();
      #1;
      check("mid_rst_rank_valid", DW'(bus.o_rank_valid), 0);
      check("mid_rst_ready", DW'(bus.o_ready), 1);
      check("mid_rst_read_valid", DW'(bus.o_read_data_valid), 0);
      check("mid_rst_read_data", bus.o_read_data, 0);
      check("mid_rst_overflow", DW'(bus.o_overflow), 0);
      check("mid_rst_ba_cmd_pm", DW'(bus.o_ba_cmd_pm), 'hA);
      cycles(2);
      @(negedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1 bus.i_rank_ready = 4'b1111;
      cycles(10);
      check("post_rst_rank_valid", DW'(bus.o_rank_valid), 0);
      check("post_rst_overflow", DW'(bus.o_overflow), 0);

      check("cmd_queue_empty", DW'(exp_cmd.size()), 0);
      check("rd_queue_empty", DW'(exp_rd.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
